// File: rtl/decodifica_multiciclo_if.sv
// Instruction fields in, datapath control out, between the multicycle control unit and its datapath.
interface decodifica_multiciclo_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       Undef;

  // Control unit side: reads the IR fields, drives every enable and select.
  modport master (
    input  Op, Funct, Rd,
    output PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc, Undef
  );

  // Datapath side: presents the IR fields, consumes the controls.
  modport slave (
    output Op, Funct, Rd,
    input  PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc, Undef
  );
endinterface

// File: rtl/decodifica_multiciclo.sv
// Multicycle ARM control unit: Moore sequencer, ALU decoder and PC-write logic.
// Write requests leave here unconditioned; the conditional stage gates them with CondEx.
module decodifica_multiciclo (
  input  logic                   CLK,
  input  logic                   RST_N,
  decodifica_multiciclo_if.master bus
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state;
  state_t state_next;

  logic       irwrite, nextpc, regw, memw, adrsrc, alusrca, branch, undef, aluop;
  logic [1:0] alusrcb, resultsrc;
  logic [1:0] alucontrol, flagw;
  logic       cmd_ok, cmd_arith;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= FETCH;
    else        state <= state_next;
  end

  // Sequencing; instruction fields are only consulted from DECODE onward.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = bus.Funct[5] ? EXECI : EXECR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  // Per-state enables and selects.
  always_comb begin
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    aluop     = 1'b0;
    branch    = 1'b0;
    undef     = 1'b0;
    case (state)
      FETCH: begin
        irwrite   = 1'b1;
        nextpc    = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        undef     = (bus.Op == 2'b11);
      end
      MEMADR: alusrcb = 2'b01;
      MEMRD:  adrsrc  = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      EXECR: aluop = 1'b1;
      EXECI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      ALUWB: regw = 1'b1;
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; unsupported commands fall back to ADD with no flag update.
  always_comb begin
    alucontrol = 2'b00;
    cmd_ok     = 1'b1;
    cmd_arith  = 1'b0;
    case (bus.Funct[4:1])
      4'b0100: begin alucontrol = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alucontrol = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alucontrol = 2'b10;
      4'b1100: alucontrol = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
    if (!aluop || !cmd_ok) begin
      alucontrol = 2'b00;
      flagw      = 2'b00;
    end else begin
      flagw = {bus.Funct[0], bus.Funct[0] & cmd_arith};
    end
  end

  // Reset forces every write enable low and parks the selects at their FETCH values.
  assign bus.IRWrite    = RST_N & irwrite;
  assign bus.NextPC     = RST_N & nextpc;
  assign bus.RegW       = RST_N & regw;
  assign bus.MemW       = RST_N & memw;
  assign bus.Undef      = RST_N & undef;
  assign bus.PCS        = RST_N & (((bus.Rd == 4'b1111) & regw) | branch);
  assign bus.FlagW      = RST_N ? flagw      : 2'b00;
  assign bus.AdrSrc     = RST_N ? adrsrc     : 1'b0;
  assign bus.ALUSrcA    = RST_N ? alusrca    : 1'b1;
  assign bus.ALUSrcB    = RST_N ? alusrcb    : 2'b10;
  assign bus.ResultSrc  = RST_N ? resultsrc  : 2'b10;
  assign bus.ALUControl = RST_N ? alucontrol : 2'b00;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_decodifica_multiciclo.sv
// Randomized instruction stream against a per-step behavioural model of the control unit.
module tb_decodifica_multiciclo;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  decodifica_multiciclo_if bus();

  decodifica_multiciclo dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       chk_en = 1'b0;
  logic       m_rst  = 1'b1;
  logic [1:0] m_op   = 2'b00;
  logic [5:0] m_funct = 6'd0;
  logic [3:0] m_rd   = 4'd0;
  int         m_step = 0;

  // {IRWrite,NextPC,RegW,MemW,PCS,Undef,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,ImmSrc,RegSrc}
  function automatic logic [19:0] dut_vec();
    return {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.PCS, bus.Undef,
            bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUControl, bus.FlagW, bus.ImmSrc, bus.RegSrc};
  endfunction

  function automatic int instr_len(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b01:   return funct[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Returns {ALUControl, FlagW} for an execute step.
  function automatic logic [3:0] alu_model(input logic [5:0] funct);
    logic s;
    s = funct[0];
    case (funct[4:1])
      4'b0100: return {2'b00, s, s};
      4'b0010: return {2'b01, s, s};
      4'b0000: return {2'b10, s, 1'b0};
      4'b1100: return {2'b11, s, 1'b0};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [19:0] model_vec(input logic rst, input logic [1:0] op,
                                            input logic [5:0] funct, input logic [3:0] rd,
                                            input int step, input logic [1:0] bus_op);
    logic       irw, npc, regw, memw, pcs, und, adr, srca;
    logic [1:0] srcb, res, ctl, fw;
    logic [3:0] alu;
    irw = 0; npc = 0; regw = 0; memw = 0; pcs = 0; und = 0; adr = 0; srca = 0;
    srcb = 0; res = 0; ctl = 0; fw = 0;
    if (rst) begin
      srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (step == 0) begin
      irw = 1; npc = 1; srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (step == 1) begin
      srca = 1; srcb = 2'b10; res = 2'b10; und = (op == 2'b11);
    end else begin
      case (op)
        2'b01: begin
          if (step == 2) srcb = 2'b01;
          else if (step == 3) begin adr = 1; memw = ~funct[0]; end
          else if (step == 4) begin res = 2'b01; regw = 1; pcs = (rd == 4'hF); end
        end
        2'b00: begin
          if (step == 2) begin
            srcb = funct[5] ? 2'b01 : 2'b00;
            alu  = alu_model(funct);
            ctl  = alu[3:2];
            fw   = alu[1:0];
          end else if (step == 3) begin
            regw = 1; pcs = (rd == 4'hF);
          end
        end
        2'b10: begin
          srcb = 2'b01; res = 2'b10; pcs = 1;
        end
        default: ;
      endcase
    end
    return {irw, npc, regw, memw, pcs, und, adr, srca, srcb, res, ctl, fw,
            bus_op, bus_op == 2'b01, bus_op == 2'b10};
  endfunction

  always @(negedge CLK) begin
    logic [19:0] got, exp;
    if (chk_en) begin
      got = dut_vec();
      exp = model_vec(m_rst, m_op, m_funct, m_rd, m_step, bus.Op);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t op=%b funct=%b rd=%h step=%0d rst=%0b got=%h exp=%h",
                 $time, m_op, m_funct, m_rd, m_step, m_rst, got, exp);
      end
    end
  end

  task automatic check_lit(input string name, input logic [19:0] mask, input logic [19:0] val);
    logic [19:0] got;
    @(negedge CLK);
    got = dut_vec() & mask;
    n_tests++;
    if (got !== val) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (mask %h)", name, got, val, mask);
    end
  endtask

  // Runs one instruction from its FETCH cycle; junk fields during FETCH, real ones after.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input int abort_step, input int lit_step, input string name,
                           input logic [19:0] mask, input logic [19:0] val);
    int len;
    len = instr_len(op, funct);
    for (int s = 0; s < len; s++) begin
      if (s == 0) begin
        bus.Op    = 2'($urandom);
        bus.Funct = 6'($urandom);
        bus.Rd    = 4'($urandom);
      end else begin
        bus.Op = op; bus.Funct = funct; bus.Rd = rd;
      end
      m_op = op; m_funct = funct; m_rd = rd; m_step = s;
      m_rst = (s == abort_step);
      RST_N = ~m_rst;
      if (s == lit_step) check_lit(name, mask, val);
      @(posedge CLK); #1;
      if (s == abort_step) begin
        RST_N = 1'b1;
        m_rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [1:0] op;
    logic [3:0] cmd, rd;
    logic [5:0] funct;
    int len, ab;
    RST_N = 1'b0;
    bus.Op = 2'b11; bus.Funct = 6'd0; bus.Rd = 4'hF;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    check_lit("reset_enables", 20'hFC000, 20'h00000);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    m_rst = 1'b0;

    run_instr(2'b00, 6'b100101, 4'h2, -1, 0, "first_fetch",   20'hC0C00, 20'hC0800);
    run_instr(2'b00, 6'b100101, 4'h3, -1, 2, "subs_exec",     20'h00CF0, 20'h00470);
    run_instr(2'b00, 6'b111001, 4'h4, -1, 2, "orrs_flagw",    20'h00030, 20'h00020);
    run_instr(2'b01, 6'b011001, 4'hF, -1, 4, "ldr_wb_pcs",    20'h28300, 20'h28100);
    run_instr(2'b01, 6'b011000, 4'h5, -1, 3, "str_memw",      20'h32000, 20'h12000);
    run_instr(2'b10, 6'b000000, 4'h0, -1, 2, "branch_pcs",    20'h08F00, 20'h08600);
    run_instr(2'b11, 6'b000000, 4'h0, -1, 1, "undef_pulse",   20'h04000, 20'h04000);
    run_instr(2'b01, 6'b011001, 4'hF,  4, 4, "ldr_abort_wb",  20'hFC000, 20'h00000);
    run_instr(2'b00, 6'b001000, 4'hF, -1, 3, "add_wb_r15",    20'h28000, 20'h28000);

    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 4))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        default: cmd = 4'($urandom);
      endcase
      funct = {1'($urandom), cmd, 1'($urandom)};
      rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      len   = instr_len(op, funct);
      ab    = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len - 1) : -1;
      run_instr(op, funct, rd, ab, -1, "", 20'h0, 20'h0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
